// File: rtl/dotmatrix_nav.sv
// rtl/dotmatrix_nav.sv - one-hot dot-matrix cursor with clamp/wrap edges and auto-repeat
module dotmatrix_nav #(
   parameter int ROWS         = 4,
   parameter int COLS         = 4,
   parameter int WRAP         = 0,
   parameter int REPEAT_DELAY = 8,
   parameter int REPEAT_RATE  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    power,
   input  logic                    up,
   input  logic                    down,
   input  logic                    left,
   input  logic                    right,
   output logic [ROWS*COLS-1:0]    y,
   output logic [$clog2(ROWS)-1:0] pos_row,
   output logic [$clog2(COLS)-1:0] pos_col,
   output logic                    moved
);

   localparam int RW      = $clog2(ROWS);
   localparam int CW      = $clog2(COLS);
   localparam int N       = ROWS * COLS;
   localparam int IW      = $clog2(N);
   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int HW      = $clog2(CNT_MAX + 1);

   // Counter values at which the first and the later repeat steps fire.
   localparam logic [HW-1:0] DELAY_LAST = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
   localparam logic [N-1:0]  ONE_HOT0   = N'(1);

   logic [3:0]    d_cur;
   logic [3:0]    d_prev_q, d_prev_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          rep_q, rep_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [N-1:0]  y_q, y_d;
   logic          moved_q, moved_d;
   logic          press, held, fire, step;
   logic [IW-1:0] idx;

   assign d_cur = {up, down, left, right};

   // Press/repeat detection, next position with clamp or wrap, display and moved pulse.
   always_comb begin
      d_prev_d = d_cur;
      hold_d   = '0;
      rep_d    = 1'b0;
      row_d    = row_q;
      col_d    = col_q;

      press = power && (d_cur != 4'b0000) && (d_cur != d_prev_q);
      held  = power && (d_cur != 4'b0000) && (d_cur == d_prev_q);
      fire  = held && (REPEAT_DELAY > 0) &&
              (rep_q ? (hold_q == RATE_LAST) : (hold_q == DELAY_LAST));
      step  = press || fire;

      // rep_q marks that the initial delay has elapsed; the counter then
      // restarts at every step so later steps are spaced by the rate.
      if (press) begin
         hold_d = '0;
         rep_d  = 1'b0;
      end else if (fire) begin
         hold_d = '0;
         rep_d  = 1'b1;
      end else if (held) begin
         hold_d = (hold_q == {HW{1'b1}}) ? hold_q : hold_q + 1'b1;
         rep_d  = rep_q;
      end

      if (step) begin
         if (up && !down) begin
            if (row_q != '0)         row_d = row_q - 1'b1;
            else if (WRAP != 0)      row_d = ROW_LAST;
         end else if (down && !up) begin
            if (row_q != ROW_LAST)   row_d = row_q + 1'b1;
            else if (WRAP != 0)      row_d = '0;
         end
         if (left && !right) begin
            if (col_q != '0)         col_d = col_q - 1'b1;
            else if (WRAP != 0)      col_d = COL_LAST;
         end else if (right && !left) begin
            if (col_q != COL_LAST)   col_d = col_q + 1'b1;
            else if (WRAP != 0)      col_d = '0;
         end
      end

      idx     = IW'(row_d) * IW'(COLS) + IW'(col_d);
      y_d     = power ? (ONE_HOT0 << idx) : '0;
      moved_d = (row_d != row_q) || (col_d != col_q);
   end

   // State registers; reset wins over power and buttons.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_prev_q <= '0;
         hold_q   <= '0;
         rep_q    <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         y_q      <= '0;
         moved_q  <= 1'b0;
      end else begin
         d_prev_q <= d_prev_d;
         hold_q   <= hold_d;
         rep_q    <= rep_d;
         row_q    <= row_d;
         col_q    <= col_d;
         y_q      <= y_d;
         moved_q  <= moved_d;
      end
   end

   assign y       = y_q;
   assign pos_row = row_q;
   assign pos_col = col_q;
   assign moved   = moved_q;

endmodule

// File: tb/tb_dotmatrix_nav.sv
// tb/tb_dotmatrix_nav.sv - directed vector bench for dotmatrix_nav (4x4 clamp and 3x5 wrap)
module tb_dotmatrix_nav;

   localparam logic [3:0] U = 4'b1000;
   localparam logic [3:0] D = 4'b0100;
   localparam logic [3:0] L = 4'b0010;
   localparam logic [3:0] R = 4'b0001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_a, power_a, up_a, down_a, left_a, right_a;
   logic [15:0] y_a;
   logic [1:0]  pos_row_a;
   logic [1:0]  pos_col_a;
   logic        moved_a;

   logic        reset_b, power_b, up_b, down_b, left_b, right_b;
   logic [14:0] y_b;
   logic [1:0]  pos_row_b;
   logic [2:0]  pos_col_b;
   logic        moved_b;

   dotmatrix_nav #(.ROWS(4), .COLS(4), .WRAP(0), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut_a (
      .clk(clk), .reset(reset_a), .power(power_a),
      .up(up_a), .down(down_a), .left(left_a), .right(right_a),
      .y(y_a), .pos_row(pos_row_a), .pos_col(pos_col_a), .moved(moved_a)
   );

   dotmatrix_nav #(.ROWS(3), .COLS(5), .WRAP(1), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut_b (
      .clk(clk), .reset(reset_b), .power(power_b),
      .up(up_b), .down(down_b), .left(left_b), .right(right_b),
      .y(y_b), .pos_row(pos_row_b), .pos_col(pos_col_b), .moved(moved_b)
   );

   typedef struct {
      logic        sel;
      logic        rst;
      logic        pwr;
      logic [3:0]  d;
      logic [1:0]  er;
      logic [2:0]  ec;
      logic [15:0] ey;
      logic        em;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic sel, input logic rst, input logic pwr, input logic [3:0] d,
                               input logic [1:0] er, input logic [2:0] ec, input logic [15:0] ey,
                               input logic em);
      vec_t v;
      v.sel = sel; v.rst = rst; v.pwr = pwr; v.d = d;
      v.er = er; v.ec = ec; v.ey = ey; v.em = em;
      return v;
   endfunction

   task automatic drive_a(input logic rst, input logic pwr, input logic [3:0] d);
      reset_a = rst; power_a = pwr;
      {up_a, down_a, left_a, right_a} = d;
   endtask

   task automatic drive_b(input logic rst, input logic pwr, input logic [3:0] d);
      reset_b = rst; power_b = pwr;
      {up_b, down_b, left_b, right_b} = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm,
                        input logic [1:0] gr, input logic [2:0] gc, input logic [15:0] gy, input logic gm,
                        input logic [1:0] er, input logic [2:0] ec, input logic [15:0] ey, input logic em);
      n_vec++;
      if ({gr, gc, gy, gm} !== {er, ec, ey, em}) begin
         n_bad++;
         $display("FAIL %s: got row=%0d col=%0d y=%h moved=%b, want row=%0d col=%0d y=%h moved=%b",
                  nm, gr, gc, gy, gm, er, ec, ey, em);
      end
   endtask

   task automatic check_a(input string nm, input logic [1:0] er, input logic [2:0] ec,
                          input logic [15:0] ey, input logic em);
      check(nm, pos_row_a, {1'b0, pos_col_a}, y_a, moved_a, er, ec, ey, em);
   endtask

   initial begin
      logic [1:0]  er;
      logic [15:0] ey;
      logic        em;

      drive_a(1'b1, 1'b1, 4'b0000);
      drive_b(1'b1, 1'b1, 4'b0000);

      // 4x4 clamp instance
      vq.push_back(mk(0, 1, 1, 4'b0000, 0, 0, 16'h0000, 0));
      vq.push_back(mk(0, 0, 1, 4'b0000, 0, 0, 16'h0001, 0));
      vq.push_back(mk(0, 0, 1, 4'b0000, 0, 0, 16'h0001, 0));
      vq.push_back(mk(0, 0, 1, D,       1, 0, 16'h0010, 1));
      vq.push_back(mk(0, 0, 1, R,       1, 1, 16'h0020, 1));
      vq.push_back(mk(0, 0, 1, 4'b0000, 1, 1, 16'h0020, 0));
      vq.push_back(mk(0, 0, 1, U|D|R,   1, 2, 16'h0040, 1));
      vq.push_back(mk(0, 0, 1, U|D,     1, 2, 16'h0040, 0));
      vq.push_back(mk(0, 0, 1, 4'b0000, 1, 2, 16'h0040, 0));
      vq.push_back(mk(0, 0, 1, U,       0, 2, 16'h0004, 1));
      vq.push_back(mk(0, 0, 1, 4'b0000, 0, 2, 16'h0004, 0));
      vq.push_back(mk(0, 0, 1, U,       0, 2, 16'h0004, 0));
      vq.push_back(mk(0, 0, 1, 4'b0000, 0, 2, 16'h0004, 0));
      vq.push_back(mk(0, 0, 1, L,       0, 1, 16'h0002, 1));
      vq.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 16'h0002, 0));
      vq.push_back(mk(0, 0, 1, U|L,     0, 0, 16'h0001, 1));
      vq.push_back(mk(0, 0, 1, 4'b0000, 0, 0, 16'h0001, 0));
      vq.push_back(mk(0, 0, 1, U|L,     0, 0, 16'h0001, 0));
      vq.push_back(mk(0, 0, 1, 4'b0000, 0, 0, 16'h0001, 0));
      vq.push_back(mk(0, 0, 1, D|R,     1, 1, 16'h0020, 1));
      vq.push_back(mk(0, 0, 1, 4'b0000, 1, 1, 16'h0020, 0));
      vq.push_back(mk(0, 0, 1, D|R,     2, 2, 16'h0400, 1));
      vq.push_back(mk(0, 0, 1, 4'b0000, 2, 2, 16'h0400, 0));
      vq.push_back(mk(0, 0, 0, R,       2, 2, 16'h0000, 0));
      vq.push_back(mk(0, 0, 0, R,       2, 2, 16'h0000, 0));
      vq.push_back(mk(0, 0, 1, R,       2, 2, 16'h0400, 0));
      vq.push_back(mk(0, 0, 1, 4'b0000, 2, 2, 16'h0400, 0));
      vq.push_back(mk(0, 0, 1, R,       2, 3, 16'h0800, 1));
      vq.push_back(mk(0, 0, 1, 4'b0000, 2, 3, 16'h0800, 0));
      vq.push_back(mk(0, 0, 1, R,       2, 3, 16'h0800, 0));
      vq.push_back(mk(0, 0, 1, 4'b0000, 2, 3, 16'h0800, 0));
      vq.push_back(mk(0, 0, 1, D,       3, 3, 16'h8000, 1));
      vq.push_back(mk(0, 0, 1, 4'b0000, 3, 3, 16'h8000, 0));
      vq.push_back(mk(0, 0, 1, D|R,     3, 3, 16'h8000, 0));
      vq.push_back(mk(0, 0, 1, 4'b0000, 3, 3, 16'h8000, 0));
      vq.push_back(mk(0, 1, 1, D,       0, 0, 16'h0000, 0));
      vq.push_back(mk(0, 0, 1, D,       1, 0, 16'h0010, 1));
      vq.push_back(mk(0, 0, 1, D,       1, 0, 16'h0010, 0));
      vq.push_back(mk(0, 0, 1, D,       1, 0, 16'h0010, 0));
      vq.push_back(mk(0, 1, 1, D,       0, 0, 16'h0000, 0));
      vq.push_back(mk(0, 1, 1, 4'b0000, 0, 0, 16'h0000, 0));
      vq.push_back(mk(0, 0, 1, 4'b0000, 0, 0, 16'h0001, 0));
      // 3x5 wrap instance
      vq.push_back(mk(1, 1, 1, 4'b0000, 0, 0, 16'h0000, 0));
      vq.push_back(mk(1, 0, 1, 4'b0000, 0, 0, 16'h0001, 0));
      vq.push_back(mk(1, 0, 1, U,       2, 0, 16'h0400, 1));
      vq.push_back(mk(1, 0, 1, 4'b0000, 2, 0, 16'h0400, 0));
      vq.push_back(mk(1, 0, 1, L,       2, 4, 16'h4000, 1));
      vq.push_back(mk(1, 0, 1, 4'b0000, 2, 4, 16'h4000, 0));
      vq.push_back(mk(1, 0, 1, D,       0, 4, 16'h0010, 1));
      vq.push_back(mk(1, 0, 1, 4'b0000, 0, 4, 16'h0010, 0));
      vq.push_back(mk(1, 0, 1, R,       0, 0, 16'h0001, 1));
      vq.push_back(mk(1, 0, 1, 4'b0000, 0, 0, 16'h0001, 0));

      foreach (vq[i]) begin
         if (vq[i].sel == 1'b0) drive_a(vq[i].rst, vq[i].pwr, vq[i].d);
         else                   drive_b(vq[i].rst, vq[i].pwr, vq[i].d);
         tick();
         if (vq[i].sel == 1'b0)
            check($sformatf("vec%0d", i), pos_row_a, {1'b0, pos_col_a}, y_a, moved_a,
                  vq[i].er, vq[i].ec, vq[i].ey, vq[i].em);
         else
            check($sformatf("vec%0d", i), pos_row_b, pos_col_b, {1'b0, y_b}, moved_b,
                  vq[i].er, vq[i].ec, vq[i].ey, vq[i].em);
      end

      // Hold down 20 cycles from (0,0): steps at k, k+8, k+12, then clamped.
      for (int j = 0; j < 20; j++) begin
         drive_a(1'b0, 1'b1, D);
         tick();
         er = (j < 8) ? 2'd1 : (j < 12) ? 2'd2 : 2'd3;
         ey = 16'h0001 << (4 * er);
         em = (j == 0) || (j == 8) || (j == 12);
         check_a($sformatf("hold_down_%0d", j), er, 3'd0, ey, em);
      end

      // Reset right where the first repeat would fire, then resume holding.
      drive_a(1'b1, 1'b1, 4'b0000);
      tick();
      drive_a(1'b0, 1'b1, 4'b0000);
      tick();
      check_a("pre_abort_idle", 2'd0, 3'd0, 16'h0001, 1'b0);
      for (int j = 0; j < 13; j++) begin
         drive_a((j == 8) ? 1'b1 : 1'b0, 1'b1, D);
         tick();
         if (j < 8)       check_a($sformatf("abort_%0d", j), 2'd1, 3'd0, 16'h0010, j == 0);
         else if (j == 8) check_a("abort_reset", 2'd0, 3'd0, 16'h0000, 1'b0);
         else             check_a($sformatf("abort_%0d", j), 2'd1, 3'd0, 16'h0010, j == 9);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
